// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between IFU fetches and LSU loads/stores, one access in flight.
// Build macro MISALIGN_CHK_EN: misaligned LSU accesses are answered with ls_err and never reach memory.
module mem_port_arbiter #(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [3:0]  ls_be,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic        owner_ls_q, owner_ls_d;
  logic        store_q, store_d;
  logic        bad_q, bad_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  starve_q, starve_d;
  logic        if_gnt_q, if_gnt_d;
  logic        if_rvalid_q, if_rvalid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        ls_gnt_q, ls_gnt_d;
  logic        ls_rvalid_q, ls_rvalid_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;
  logic        ls_err_q, ls_err_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        pick_ls;
  logic        bad_req;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^if_addr[1:0];

`ifdef MISALIGN_CHK_EN
  always_comb begin
    bad_req = 1'b1;
    case (ls_be)
      4'b1111:                            bad_req = (ls_addr[1:0] != 2'b00);
      4'b0011, 4'b1100:                   bad_req = ls_addr[0];
      4'b0001, 4'b0010, 4'b0100, 4'b1000: bad_req = 1'b0;
      default:                            bad_req = 1'b1;
    endcase
  end
`else
  assign bad_req = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    owner_ls_d  = owner_ls_q;
    store_d     = store_q;
    bad_d       = bad_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    pick_ls     = 1'b0;
    if_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    if_rdata_d  = '0;
    ls_gnt_d    = 1'b0;
    ls_rvalid_d = 1'b0;
    ls_rdata_d  = '0;
    ls_err_d    = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_be_d    = '0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    case (state_q)
      IDLE: begin
        if (if_req || ls_req) begin
          // LSU wins unless a waiting IFU has been passed over STARVE_LIMIT times in a row
          pick_ls = ls_req && !(if_req && (STARVE_LIMIT != 0) &&
                                (starve_q == 4'(STARVE_LIMIT)));
          owner_ls_d = pick_ls;
          state_d    = ISSUE;
          if (pick_ls) begin
            ls_gnt_d = 1'b1;
            store_d  = ls_we;
            bad_d    = bad_req;
            starve_d = !if_req ? 4'd0 : (starve_q == 4'hf) ? 4'hf : starve_q + 4'd1;
            if (!bad_req) begin
              mem_en_d    = 1'b1;
              mem_we_d    = ls_we;
              mem_be_d    = ls_be;
              mem_addr_d  = ls_addr;
              mem_wdata_d = ls_wdata;
            end
          end else begin
            if_gnt_d   = 1'b1;
            store_d    = 1'b0;
            bad_d      = 1'b0;
            starve_d   = 4'd0;
            mem_en_d   = 1'b1;
            mem_be_d   = 4'b1111;
            mem_addr_d = {if_addr[31:2], 2'b00};
          end
        end
      end
      ISSUE: begin
        if (bad_q) begin
          state_d     = RESP;
          ls_rvalid_d = 1'b1;
          ls_err_d    = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = 3'(MEM_LATENCY);
        end
      end
      WAIT: begin
        if (cnt_q <= 3'd1) begin
          state_d = RESP;
          if (owner_ls_q) begin
            ls_rvalid_d = 1'b1;
            ls_rdata_d  = store_q ? 32'd0 : mem_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_ls_q  <= 1'b0;
      store_q     <= 1'b0;
      bad_q       <= 1'b0;
      cnt_q       <= '0;
      starve_q    <= '0;
      if_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_gnt_q    <= 1'b0;
      ls_rvalid_q <= 1'b0;
      ls_rdata_q  <= '0;
      ls_err_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_ls_q  <= owner_ls_d;
      store_q     <= store_d;
      bad_q       <= bad_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      if_gnt_q    <= if_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_gnt_q    <= ls_gnt_d;
      ls_rvalid_q <= ls_rvalid_d;
      ls_rdata_q  <= ls_rdata_d;
      ls_err_q    <= ls_err_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign ls_gnt    = ls_gnt_q;
  assign ls_rvalid = ls_rvalid_q;
  assign ls_rdata  = ls_rdata_q;
  assign ls_err    = ls_err_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: random requesters, a latency-accurate memory, and a cycle-level reference scoreboard.
module tb_mem_port_arbiter;

  localparam int LAT  = 3;
  localparam int SLIM = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req, ls_we;
  logic [3:0]  ls_be;
  logic [31:0] ls_addr, ls_wdata;
  logic        ls_gnt, ls_rvalid, ls_err;
  logic [31:0] ls_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'd0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(SLIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct {
    int unsigned cyc;
    logic [1:0]  who;   // {ifu, lsu}
    logic        en;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } gexp_t;

  typedef struct {
    int unsigned cyc;
    logic [1:0]  who;
    logic [31:0] rdata;
    logic        err;
  } rexp_t;

  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  gexp_t       gq[$];
  rexp_t       rq[$];
  logic [1:0]  gseq[$];
  bit          rec_seq = 0;
  bit          drv_en = 0;
  int          p_req = 30;
  int          p_drop = 3;
  logic [31:0] ref_mem [logic [29:0]];
  logic [31:0] dev_mem [logic [29:0]];
  logic [32:0] pipe [0:7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] init_word(input logic [29:0] w);
    return {w[15:0], ~w[15:0]} ^ 32'hA5C3_0F96;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~m) | (nw & m);
  endfunction

  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : init_word(a[31:2]);
  endfunction

  function automatic logic [31:0] rd_dev(input logic [31:0] a);
    return dev_mem.exists(a[31:2]) ? dev_mem[a[31:2]] : init_word(a[31:2]);
  endfunction

  function automatic bit ls_legal(input logic [3:0] be, input logic [1:0] a);
    return (be == 4'hf && a == 2'b00) || ((be == 4'h3 || be == 4'hc) && !a[0]) || ($countones(be) == 1);
  endfunction

  // Reference: one transaction occupies LAT+3 cycles (3 when rejected as misaligned)
  initial begin : ref_model
    int unsigned next_idle;
    int          starve_m;
    bit          take_ls, bad;
    gexp_t       ge;
    rexp_t       re;
    next_idle = 0;
    starve_m  = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        starve_m = 0;
        gq.delete();
        rq.delete();
        next_idle = cyc + 1;
      end else if (cyc >= next_idle && (if_req || ls_req)) begin
        take_ls = ls_req && !(if_req && SLIM != 0 && starve_m == SLIM);
        if (take_ls) begin
          bad = 1'b0;
`ifdef MISALIGN_CHK_EN
          bad = !ls_legal(ls_be, ls_addr[1:0]);
`endif
          ge.cyc = cyc + 1; ge.who = 2'b01; ge.en = !bad;
          ge.we = bad ? 1'b0 : ls_we;
          ge.be = bad ? 4'h0 : ls_be;
          ge.addr = bad ? 32'd0 : ls_addr;
          ge.wdata = bad ? 32'd0 : ls_wdata;
          re.cyc = bad ? cyc + 2 : cyc + 2 + LAT;
          re.who = 2'b01; re.err = bad;
          re.rdata = (bad || ls_we) ? 32'd0 : rd_ref(ls_addr);
          if (!bad && ls_we) ref_mem[ls_addr[31:2]] = merge(rd_ref(ls_addr), ls_wdata, ls_be);
          next_idle = bad ? cyc + 3 : cyc + 3 + LAT;
          starve_m = !if_req ? 0 : (starve_m < 15 ? starve_m + 1 : 15);
        end else begin
          ge.cyc = cyc + 1; ge.who = 2'b10; ge.en = 1'b1; ge.we = 1'b0; ge.be = 4'hf;
          ge.addr = {if_addr[31:2], 2'b00}; ge.wdata = 32'd0;
          re.cyc = cyc + 2 + LAT; re.who = 2'b10; re.err = 1'b0; re.rdata = rd_ref(if_addr);
          next_idle = cyc + 3 + LAT;
          starve_m = 0;
        end
        gq.push_back(ge);
        rq.push_back(re);
      end
      cyc++;
    end
  end

  // Memory: data for a read issued in cycle k is presented throughout cycle k+LAT, garbage otherwise
  initial begin
    for (int i = 0; i < 8; i++) pipe[i] = '0;
    forever begin
      @(negedge clk);
      for (int i = 7; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = '0;
      if (mem_en === 1'b1) begin
        if (mem_we) dev_mem[mem_addr[31:2]] = merge(rd_dev(mem_addr), mem_wdata, mem_be);
        else pipe[0] = {1'b1, rd_dev(mem_addr)};
      end
      mem_rdata = pipe[LAT][32] ? pipe[LAT][31:0] : $urandom();
    end
  end

  initial begin : monitor
    logic [1:0]  g, r;
    logic [31:0] rd;
    gexp_t       ge;
    rexp_t       re;
    forever begin
      @(negedge clk);
      g = {if_gnt, ls_gnt};
      r = {if_rvalid, ls_rvalid};
      if (g != 2'b00) begin
        if (gq.size() == 0) chk("gnt_unexpected", 64'(g), 64'd0);
        else begin
          ge = gq.pop_front();
          chk("gnt_who_cycle", {30'd0, g, cyc}, {30'd0, ge.who, ge.cyc});
          chk("mem_ctl", {58'd0, mem_en, mem_we, mem_be}, {58'd0, ge.en, ge.we, ge.be});
          chk("mem_addr_wdata", {mem_addr, mem_wdata}, {ge.addr, ge.wdata});
          if (rec_seq) gseq.push_back(g);
        end
      end else if (mem_en === 1'b1) begin
        chk("mem_en_without_gnt", 64'(mem_en), 64'd0);
      end
      if (r != 2'b00) begin
        if (rq.size() == 0) chk("rvalid_unexpected", 64'(r), 64'd0);
        else begin
          re = rq.pop_front();
          rd = r[0] ? ls_rdata : if_rdata;
          chk("rsp_who_cycle", {30'd0, r, cyc}, {30'd0, re.who, re.cyc});
          chk("rsp_data_err", {31'd0, rd, ls_err}, {31'd0, re.rdata, re.err});
          chk("rsp_no_mem_en", 64'(mem_en), 64'd0);
        end
      end
    end
  end

  // Requesters: inputs held until gnt, optional withdrawal, new request may follow a grant at once
  initial begin : drivers
    bit new_if, new_ls;
    forever begin
      @(negedge clk);
      if (drv_en) begin
        new_if = !if_req;
        if (if_req && if_gnt) begin if_req = 1'b0; new_if = 1'b1; end
        else if (if_req && $urandom_range(0, 99) < p_drop) if_req = 1'b0;
        if (new_if && $urandom_range(0, 99) < p_req) begin
          if_req = 1'b1; if_addr = $urandom_range(0, 255);
        end
        new_ls = !ls_req;
        if (ls_req && ls_gnt) begin ls_req = 1'b0; new_ls = 1'b1; end
        else if (ls_req && $urandom_range(0, 99) < p_drop) ls_req = 1'b0;
        if (new_ls && $urandom_range(0, 99) < p_req) begin
          ls_req = 1'b1; ls_we = 1'($urandom_range(0, 1)); ls_be = 4'($urandom_range(0, 15));
          ls_addr = $urandom_range(0, 255); ls_wdata = $urandom();
        end
      end
    end
  end

  task automatic wait_gnt(input bit is_ls);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(is_ls ? ls_gnt : if_gnt) && k < 40);
    if (k >= 40) chk("gnt_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int k = 0;
    while ((gq.size() + rq.size()) != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("drain_queues", 64'(gq.size() + rq.size()), 64'd0);
    repeat (LAT + 4) @(negedge clk);
  endtask

  initial begin
    logic [1:0] exp_seq [6];
    int k;
    exp_seq = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
    ls_be = '0; ls_addr = '0; ls_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", {53'd0, if_gnt, if_rvalid, ls_gnt, ls_rvalid, ls_err, mem_en, mem_we, mem_be}, 64'd0);
    chk("reset_rdata", {if_rdata, ls_rdata}, 64'd0);
    chk("reset_mem", {mem_addr, mem_wdata}, 64'd0);
    rst_n = 1'b1;

    // single fetch from an unaligned address
    if_addr = 32'h0000_0013; if_req = 1'b1;
    wait_gnt(1'b0);
    if_req = 1'b0;
    drain();

    // half-word store
    ls_we = 1'b1; ls_be = 4'b0011; ls_addr = 32'h0000_0202; ls_wdata = 32'h0000_BEEF; ls_req = 1'b1;
    wait_gnt(1'b1);
    ls_req = 1'b0;
    drain();

    // randomized traffic
    drv_en = 1'b1;
    repeat (2500) @(negedge clk);
    drv_en = 1'b0;
    @(negedge clk);
    if_req = 1'b0; ls_req = 1'b0;
    drain();

    // reset while the memory access is outstanding: no response may follow
    if_addr = 32'h0000_0040; if_req = 1'b1;
    wait_gnt(1'b0);
    if_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_reset_ctl", {53'd0, if_gnt, if_rvalid, ls_gnt, ls_rvalid, ls_err, mem_en, mem_we, mem_be}, 64'd0);
    chk("post_reset_data", {if_rdata, ls_rdata}, 64'd0);
    repeat (LAT + 5) @(negedge clk);

    // both requesters held busy: starvation guard sets the grant order
    rec_seq = 1'b1; p_req = 100; p_drop = 0; drv_en = 1'b1;
    k = 0;
    while (gseq.size() < 6 && k < 200) begin
      @(negedge clk);
      k++;
    end
    drv_en = 1'b0;
    @(negedge clk);
    if_req = 1'b0; ls_req = 1'b0; rec_seq = 1'b0;
    if (gseq.size() < 6) chk("starve_seq_len", 64'(gseq.size()), 64'd6);
    else for (int i = 0; i < 6; i++) chk("starve_order", 64'(gseq[i]), 64'(exp_seq[i]));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
